// File: rtl/mont_op_sequencer_if.sv
// Handshake bundle between the Montgomery op sequencer and its environment.
//   cmd_*    : command word from the producer (valid held until cmd_read pulse)
//   opnd_*   : operand transfers from the 1024-bit buffer read port
//   core_*   : operands, start and result to/from the Montgomery multiplier core
//   res_*    : result write request to the buffer write port
//   status_* : completion/error report, held until status_read
//   busy     : sequencer is not idle
// master is the sequencer side; slave is the environment side.
interface mont_op_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned CMD_WIDTH  = 32
);
  logic [CMD_WIDTH-1:0]  cmd_data;
  logic                  cmd_valid;
  logic                  cmd_read;
  logic [DATA_WIDTH-1:0] opnd_data;
  logic                  opnd_valid;
  logic [DATA_WIDTH-1:0] core_a;
  logic [DATA_WIDTH-1:0] core_b;
  logic [DATA_WIDTH-1:0] core_m;
  logic                  core_start;
  logic                  core_done;
  logic [DATA_WIDTH-1:0] core_result;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_valid;
  logic                  res_read;
  logic                  status_valid;
  logic                  status_err;
  logic                  status_read;
  logic                  busy;

  modport master (
    input  cmd_data, cmd_valid, opnd_data, opnd_valid, core_done, core_result, res_read,
           status_read,
    output cmd_read, core_a, core_b, core_m, core_start, res_data, res_valid, status_valid,
           status_err, busy
  );

  modport slave (
    output cmd_data, cmd_valid, opnd_data, opnd_valid, core_done, core_result, res_read,
           status_read,
    input  cmd_read, core_a, core_b, core_m, core_start, res_data, res_valid, status_valid,
           status_err, busy
  );
endinterface

// File: rtl/mont_op_sequencer.sv
// Command sequencer between the 1024-bit operand buffer and the Montgomery multiplier core.
// Accepts a command (opcode in cmd_data[1:0]), captures the operands it needs from the
// buffer's wide read port, starts the core, writes the result back and reports status.
//   Opcodes: 00 CLR, 01 LOAD_M, 10 MUL (A then B), 11 MUL_A (A only, reuses B).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state and outputs
//   bus   : mont_op_sequencer_if.master (command, operand, core, result, status handshakes)
module mont_op_sequencer #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned CMD_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  mont_op_sequencer_if.master        bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StWrite, StStatus} state_e;
  typedef enum logic [1:0] {
    OpClr   = 2'b00,
    OpLoadM = 2'b01,
    OpMul   = 2'b10,
    OpMulA  = 2'b11
  } op_e;

  state_e                state_q;
  op_e                   op_q;
  logic [1:0]            cnt_q;
  logic                  m_loaded_q;
  logic                  b_loaded_q;
  logic [DATA_WIDTH-1:0] core_a_q;
  logic [DATA_WIDTH-1:0] core_b_q;
  logic [DATA_WIDTH-1:0] core_m_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  cmd_read_q;
  logic                  core_start_q;
  logic                  res_valid_q;
  logic                  status_valid_q;
  logic                  status_err_q;

  op_e cmd_op;
  assign cmd_op = op_e'(bus.cmd_data[1:0]);

  // Upper command bits carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^bus.cmd_data[CMD_WIDTH-1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      op_q           <= OpClr;
      cnt_q          <= 2'd0;
      m_loaded_q     <= 1'b0;
      b_loaded_q     <= 1'b0;
      core_a_q       <= '0;
      core_b_q       <= '0;
      core_m_q       <= '0;
      res_data_q     <= '0;
      cmd_read_q     <= 1'b0;
      core_start_q   <= 1'b0;
      res_valid_q    <= 1'b0;
      status_valid_q <= 1'b0;
      status_err_q   <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      cmd_read_q   <= 1'b0;
      core_start_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            cmd_read_q <= 1'b1;
            op_q       <= cmd_op;
            cnt_q      <= 2'd0;
            unique case (cmd_op)
              OpClr: begin
                m_loaded_q     <= 1'b0;
                b_loaded_q     <= 1'b0;
                status_valid_q <= 1'b1;
                status_err_q   <= 1'b0;
                state_q        <= StStatus;
              end
              OpLoadM: state_q <= StLoad;
              OpMul: begin
                if (!m_loaded_q) begin
                  status_valid_q <= 1'b1;
                  status_err_q   <= 1'b1;
                  state_q        <= StStatus;
                end else begin
                  state_q <= StLoad;
                end
              end
              OpMulA: begin
                if (!m_loaded_q || !b_loaded_q) begin
                  status_valid_q <= 1'b1;
                  status_err_q   <= 1'b1;
                  state_q        <= StStatus;
                end else begin
                  state_q <= StLoad;
                end
              end
            endcase
          end
        end

        StLoad: begin
          if (bus.opnd_valid) begin
            cnt_q <= cnt_q + 2'd1;
            unique case (op_q)
              OpLoadM: begin
                core_m_q       <= bus.opnd_data;
                m_loaded_q     <= 1'b1;
                status_valid_q <= 1'b1;
                status_err_q   <= 1'b0;
                state_q        <= StStatus;
              end
              OpMul: begin
                if (cnt_q == 2'd0) begin
                  core_a_q <= bus.opnd_data;
                end else begin
                  core_b_q     <= bus.opnd_data;
                  b_loaded_q   <= 1'b1;
                  core_start_q <= 1'b1;
                  state_q      <= StStart;
                end
              end
              OpMulA: begin
                core_a_q     <= bus.opnd_data;
                core_start_q <= 1'b1;
                state_q      <= StStart;
              end
              // CLR never enters LOAD; recover to idle if it somehow does.
              default: state_q <= StIdle;
            endcase
          end
        end

        // core_start was raised on entry, so it is high for exactly this cycle.
        StStart: state_q <= StWait;

        StWait: begin
          if (bus.core_done) begin
            res_data_q  <= bus.core_result;
            res_valid_q <= 1'b1;
            state_q     <= StWrite;
          end
        end

        StWrite: begin
          if (bus.res_read) begin
            res_valid_q    <= 1'b0;
            status_valid_q <= 1'b1;
            status_err_q   <= 1'b0;
            state_q        <= StStatus;
          end
        end

        StStatus: begin
          if (bus.status_read) begin
            status_valid_q <= 1'b0;
            status_err_q   <= 1'b0;
            state_q        <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_read     = cmd_read_q;
  assign bus.core_a       = core_a_q;
  assign bus.core_b       = core_b_q;
  assign bus.core_m       = core_m_q;
  assign bus.core_start   = core_start_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.status_valid = status_valid_q;
  assign bus.status_err   = status_err_q;
  assign bus.busy         = (state_q != StIdle);

endmodule
